usb_ulpi_rst_seq: RTL and testbench



---
 rtl/usb_reset_pkg.sv | 24 ++
 rtl/usb_ulpi_rst_seq.sv | 153 +++++++++++++++
 tb/tb_usb_ulpi_rst_seq.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_reset_pkg.sv
// Shared types and default timing constants for the ULPI link-side reset sequencer.
package usb_reset_pkg;

    typedef enum logic [2:0] {
        ST_PHY_RST  = 3'd0,
        ST_WAIT_DIR = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_RUN      = 3'd3,
        ST_FAIL     = 3'd4
    } rst_seq_state_e;

    localparam int unsigned PHY_RST_CYCLES_DEF = 32'd60;
    localparam int unsigned DIR_TIMEOUT_DEF    = 32'd4096;
    localparam int unsigned SETTLE_CYCLES_DEF  = 32'd16;
    localparam int unsigned MAX_RETRY_DEF      = 32'd3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_ulpi_rst_seq.sv
// Sequences PHY reset, waits for the PHY to release ulpi_dir, lets it settle,
// then releases the link core; retries the PHY reset on dir timeout.
module usb_ulpi_rst_seq
    import usb_reset_pkg::*;
#(
    parameter int unsigned PHY_RST_CYCLES = PHY_RST_CYCLES_DEF,
    parameter int unsigned DIR_TIMEOUT    = DIR_TIMEOUT_DEF,
    parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF,
    parameter int unsigned CNT_W          = 32'd13
) (
    input  logic       phy_ulpi_clk,
    input  logic       reset,
    input  logic       sw_rst_req,
    input  logic       ulpi_dir,
    output logic       phy_reset,
    output logic       link_rst,
    output logic       rst_done,
    output logic       timeout_err,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    if ((CNT_W < 32'd32 && max3(PHY_RST_CYCLES, DIR_TIMEOUT, SETTLE_CYCLES) >= (32'd1 << CNT_W))
        || PHY_RST_CYCLES < 32'd1 || DIR_TIMEOUT < 32'd4 || SETTLE_CYCLES < 32'd1
        || MAX_RETRY > 32'd3) begin : g_param_err
        $error("usb_ulpi_rst_seq: parameter set out of range for CNT_W/retry width");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DIR_LAST    = CNT_W'(DIR_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

    rst_seq_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       filt_q, filt_d;
    logic [1:0]       retry_q, retry_d;
    logic             terr_q, terr_d;

    logic             phy_reset_q, link_rst_q, rst_done_q, fail_q;
    logic [2:0]       state_o_q;

    // Next-state, counter, dir low-filter, retry and sticky timeout logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        filt_d  = filt_q;
        retry_d = retry_q;
        terr_d  = terr_q;
        if (sw_rst_req) begin
            state_d = ST_PHY_RST;
            cnt_d   = CNT_ZERO;
            filt_d  = 2'd0;
            retry_d = 2'd0;
            terr_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PHY_RST: begin
                    if (cnt_q == PHY_LAST) begin
                        state_d = ST_WAIT_DIR;
                        cnt_d   = CNT_ZERO;
                        filt_d  = 2'd0;
                    end else begin
                        filt_d  = 2'd0;
                    end
                end
                ST_WAIT_DIR: begin
                    // A completed filter beats a timeout on the same cycle.
                    if (!ulpi_dir && filt_q == 2'd1) begin
                        state_d = ST_SETTLE;
                        cnt_d   = CNT_ZERO;
                        filt_d  = 2'd0;
                    end else if (cnt_q == DIR_LAST) begin
                        terr_d  = 1'b1;
                        cnt_d   = CNT_ZERO;
                        filt_d  = 2'd0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_PHY_RST;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        filt_d  = ulpi_dir ? 2'd0 : (filt_q + 2'd1);
                    end
                end
                ST_SETTLE: begin
                    if (ulpi_dir) begin
                        state_d = ST_WAIT_DIR;
                        cnt_d   = CNT_ZERO;
                        filt_d  = 2'd0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        filt_d  = 2'd0;
                    end
                end
                ST_RUN: begin
                    cnt_d = CNT_ZERO;
                end
                ST_FAIL: begin
                    cnt_d = CNT_ZERO;
                end
                default: begin
                    state_d = ST_PHY_RST;
                    cnt_d   = CNT_ZERO;
                    filt_d  = 2'd0;
                end
            endcase
        end
    end

    // State registers; outputs are decoded from the next state so they align with state_q.
    always_ff @(posedge phy_ulpi_clk) begin
        if (reset) begin
            state_q     <= ST_PHY_RST;
            cnt_q       <= CNT_ZERO;
            filt_q      <= 2'd0;
            retry_q     <= 2'd0;
            terr_q      <= 1'b0;
            phy_reset_q <= 1'b1;
            link_rst_q  <= 1'b1;
            rst_done_q  <= 1'b0;
            fail_q      <= 1'b0;
            state_o_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            retry_q     <= retry_d;
            terr_q      <= terr_d;
            phy_reset_q <= (state_d == ST_PHY_RST);
            link_rst_q  <= (state_d != ST_RUN);
            rst_done_q  <= (state_d == ST_RUN);
            fail_q      <= (state_d == ST_FAIL);
            state_o_q   <= state_d;
        end
    end

    assign phy_reset   = phy_reset_q;
    assign link_rst    = link_rst_q;
    assign rst_done    = rst_done_q;
    assign fail        = fail_q;
    assign timeout_err = terr_q;
    assign retry_cnt   = retry_q;
    assign state_o     = state_o_q;

endmodule

// File: tb/tb_usb_ulpi_rst_seq.sv
// Self-checking bench: dir waveforms are replayed into the sequencer and every cycle is
// compared against a window-based timeline model of the reset sequence.
module tb_usb_ulpi_rst_seq;

    localparam int P    = 60;
    localparam int DT   = 4096;
    localparam int S    = 16;
    localparam int MR   = 3;
    localparam int MAXN = 17000;
    localparam int LIM  = MAXN + 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw = 1'b0;
    logic       dir = 1'b0;
    logic       phy_reset, link_rst, rst_done, timeout_err, fail;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    bit         dirs   [0:LIM];
    int         exp_st [0:LIM];
    int         exp_rt [0:LIM];
    bit         exp_te [0:LIM];
    logic [9:0] act    [0:LIM];

    int ncmp = 0;
    int nerr = 0;
    int rd_edge, pf_edge;

    usb_ulpi_rst_seq dut (
        .phy_ulpi_clk (clk),
        .reset        (reset),
        .sw_rst_req   (sw),
        .ulpi_dir     (dir),
        .phy_reset    (phy_reset),
        .link_rst     (link_rst),
        .rst_done     (rst_done),
        .timeout_err  (timeout_err),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec(input int t);
        logic [2:0] st;
        st = 3'(exp_st[t]);
        return {st, st == 3'd0, st != 3'd3, st == 3'd3, st == 3'd4, exp_te[t], 2'(exp_rt[t])};
    endfunction

    task automatic put(input int idx, input int st, input int rt, input bit te);
        if (idx <= LIM) begin
            exp_st[idx] = st;
            exp_rt[idx] = rt;
            exp_te[idx] = te;
        end
    endtask

    // Timeline model: pulse window, then a dir-wait window that ends on two low samples
    // or on the timeout, then a settle window that any high dir sample aborts.
    task automatic build_model(input int n);
        int t, ws, zeros, retry;
        bit te, ok, settled, timed;
        t = 0; retry = 0; te = 1'b0;
        put(0, 0, 0, 1'b0);
        while (t < n) begin
            for (int i = 1; i <= P; i++) put(t + i, (i == P) ? 1 : 0, retry, te);
            t += P; ws = t; zeros = 0; settled = 1'b0; timed = 1'b0;
            while (!settled && !timed && t < n) begin
                t++;
                zeros = dirs[t] ? 0 : zeros + 1;
                if (zeros >= 2) begin
                    put(t, 2, retry, te);
                    ok = 1'b1;
                    for (int j = 1; j <= S; j++) begin
                        t++;
                        if (dirs[t]) begin
                            put(t, 1, retry, te); ws = t; zeros = 0; ok = 1'b0;
                            break;
                        end
                        put(t, (j == S) ? 3 : 2, retry, te);
                    end
                    settled = ok;
                end else if (t - ws == DT) begin
                    te = 1'b1; timed = 1'b1;
                    if (retry < MR) begin
                        retry++;
                        put(t, 0, retry, te);
                    end else begin
                        for (int k = t; k <= n; k++) put(k, 4, retry, te);
                        t = n;
                    end
                end else begin
                    put(t, 1, retry, te);
                end
            end
            if (settled) begin
                for (int k = t + 1; k <= n; k++) put(k, 3, retry, te);
                t = n;
            end
        end
    endtask

    task automatic fill_dirs(input bit v);
        for (int i = 0; i <= LIM; i++) dirs[i] = v;
    endtask

    // Edge 0 is the restarting edge (reset and/or sw request); edges 1..n replay dirs.
    task automatic run_trace(input int n, input bit rst_start, input bit sw_start);
        rd_edge = -1; pf_edge = -1;
        reset = rst_start; sw = sw_start; dir = dirs[0];
        @(posedge clk); @(negedge clk);
        reset = 1'b0; sw = 1'b0;
        act[0] = {state_o, phy_reset, link_rst, rst_done, fail, timeout_err, retry_cnt};
        for (int t = 1; t <= n; t++) begin
            dir = dirs[t];
            @(posedge clk); @(negedge clk);
            act[t] = {state_o, phy_reset, link_rst, rst_done, fail, timeout_err, retry_cnt};
            if (rd_edge < 0 && rst_done) rd_edge = t;
            if (pf_edge < 0 && !phy_reset) pf_edge = t;
        end
        build_model(n);
    endtask

    task automatic test_reset();
        logic [9:0] rv;
        fill_dirs(1'b0);
        reset = 1'b1; dir = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rv = {state_o, phy_reset, link_rst, rst_done, fail, timeout_err, retry_cnt};
        ncmp++;
        if (rv !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            nerr++; $display("FAIL reset_values got %b exp %b", rv, 10'b0001100000);
        end
        run_trace(100, 1'b1, 1'b0);
        for (int t = 0; t <= 100; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL clean_trace t=%0d got %b exp %b", t, act[t], exp_vec(t));
                break;
            end
        end
        ncmp++;
        if (rd_edge !== 78) begin nerr++; $display("FAIL clean_latency got %0d exp 78", rd_edge); end
        ncmp++;
        if (pf_edge !== P) begin nerr++; $display("FAIL phy_pulse_len got %0d exp %0d", pf_edge, P); end
    endtask

    task automatic test_dir_held();
        fill_dirs(1'b0);
        for (int t = P + 1; t <= P + 200; t++) dirs[t] = 1'b1;
        run_trace(300, 1'b1, 1'b0);
        for (int t = 0; t <= 300; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL dir_held_trace t=%0d got %b exp %b", t, act[t], exp_vec(t));
                break;
            end
        end
        ncmp++;
        if (rd_edge - pf_edge !== 218) begin
            nerr++; $display("FAIL dir_held_latency got %0d exp 218", rd_edge - pf_edge);
        end
    endtask

    task automatic test_settle_glitch();
        fill_dirs(1'b0);
        dirs[73] = 1'b1;
        run_trace(150, 1'b1, 1'b0);
        for (int t = 0; t <= 150; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL glitch_trace t=%0d got %b exp %b", t, act[t], exp_vec(t));
                break;
            end
        end
        ncmp++;
        if (rd_edge !== 78 + 13) begin nerr++; $display("FAIL glitch_latency got %0d exp 91", rd_edge); end
    endtask

    task automatic test_stuck_dir();
        int n;
        n = 4 * (P + DT) + 20;
        fill_dirs(1'b1);
        run_trace(n, 1'b1, 1'b0);
        for (int t = 0; t <= n; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL stuck_trace t=%0d got %b exp %b", t, act[t], exp_vec(t));
                break;
            end
        end
        ncmp++;
        if ({fail, link_rst, phy_reset, retry_cnt} !== {1'b1, 1'b1, 1'b0, 2'd3}) begin
            nerr++; $display("FAIL stuck_final got %b exp 11011", {fail, link_rst, phy_reset, retry_cnt});
        end
    endtask

    task automatic test_sw_req(input string tag);
        fill_dirs(1'b0);
        run_trace(100, 1'b0, 1'b1);
        for (int t = 0; t <= 100; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL sw_%s_trace t=%0d got %b exp %b", tag, t, act[t], exp_vec(t));
                break;
            end
        end
        ncmp++;
        if (rd_edge !== 78) begin nerr++; $display("FAIL sw_%s_latency got %0d exp 78", tag, rd_edge); end
    endtask

    task automatic test_reset_with_sw();
        fill_dirs(1'b0);
        for (int t = P + 1; t <= 150; t++) dirs[t] = 1'b1;
        run_trace(150, 1'b1, 1'b0);
        ncmp++;
        if (state_o !== 3'd1) begin nerr++; $display("FAIL mid_wait_state got %0d exp 1", state_o); end
        fill_dirs(1'b0);
        run_trace(100, 1'b1, 1'b1);
        for (int t = 0; t <= 100; t++) begin
            ncmp++;
            if (act[t] !== exp_vec(t)) begin
                nerr++; $display("FAIL reset_sw_trace t=%0d got %b exp %b", t, act[t], exp_vec(t));
                break;
            end
        end
    endtask

    task automatic test_random();
        int pct, run;
        bit v, via_sw;
        for (int it = 0; it < 8; it++) begin
            pct = $urandom_range(60, 5);
            run = 0; v = 1'b0;
            fill_dirs(1'b0);
            for (int t = 1; t <= 900; t++) begin
                if (run == 0) begin
                    v = ($urandom_range(99, 0) < pct);
                    run = $urandom_range(24, 1);
                end
                dirs[t] = v;
                run--;
            end
            via_sw = 1'($urandom_range(1, 0));
            run_trace(900, !via_sw, via_sw);
            for (int t = 0; t <= 900; t++) begin
                ncmp++;
                if (act[t] !== exp_vec(t)) begin
                    nerr++; $display("FAIL random_trace it=%0d t=%0d got %b exp %b", it, t, act[t], exp_vec(t));
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_req("run");
        test_dir_held();
        test_settle_glitch();
        test_reset_with_sw();
        test_stuck_dir();
        test_sw_req("fail");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
